// File: rtl/add_vector_gen.sv
// Adder test-vector source: emits {cin, a, b} with golden sum/carry over valid/ready.
// Optional VECGEN_CORNER_EN prefixes each run with four fixed corner vectors.
module add_vector_gen #(
    parameter int          WIDTH       = 32,
    parameter int          NUM_VECTORS = 10000,
    parameter logic [31:0] SEED        = 32'h1234_5678
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             vec_ready,
    output logic             vec_valid,
    output logic             cin,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] exp_s,
    output logic             exp_cout,
    output logic [31:0]      vec_count,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start, outputs gated to 0
    // RUN   | presenting a vector, advancing on each accept
    // DONE  | run complete, vec_count holds final total
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic             cin;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } vec_t;

    localparam logic [31:0] B_MASK = 32'hDEAD_BEEF;
    localparam logic [31:0] TAPS   = 32'h8020_0003;
    localparam logic [31:0] SEED_B = SEED ^ B_MASK;

    state_t      state;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic [31:0] lfsr_a_n;
    logic [31:0] lfsr_b_n;
    logic [31:0] cnt_inc;
    logic        last;
    vec_t        run_vec;
    vec_t        first_vec;
    logic [WIDTH:0] run_sum;
    logic [WIDTH:0] first_sum;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : 32'h0);
    endfunction

    function automatic vec_t lfsr_vec(input logic [31:0] la, input logic [31:0] lb);
        vec_t v;
        v.a   = la[WIDTH-1:0];
        v.b   = lb[WIDTH-1:0];
        v.cin = la[31] ^ lb[0];
        return v;
    endfunction

    function automatic logic [WIDTH:0] vec_sum(input vec_t v);
        return {1'b0, v.a} + {1'b0, v.b} + {{WIDTH{1'b0}}, v.cin};
    endfunction

`ifdef VECGEN_CORNER_EN
    localparam logic [31:0] ALT_A = 32'h5555_5555;
    localparam logic [31:0] ALT_B = 32'hAAAA_AAAA;

    // cidx counts issued corners; bit 2 set means the corner phase is over
    logic [2:0] cidx;
    logic [2:0] cidx_n;
    logic       in_corner;

    function automatic vec_t corner_vec(input logic [1:0] idx);
        vec_t v;
        v = '0;
        case (idx)
            2'd1: begin v.a = '1; v.b = '1; v.cin = 1'b1; end
            2'd2: begin v.a = '1; v.b = '0; v.cin = 1'b1; end
            2'd3: begin v.a = ALT_A[WIDTH-1:0]; v.b = ALT_B[WIDTH-1:0]; end
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        in_corner = ~cidx[2];
        lfsr_a_n  = in_corner ? lfsr_a : lfsr_step(lfsr_a);
        lfsr_b_n  = in_corner ? lfsr_b : lfsr_step(lfsr_b);
        cidx_n    = in_corner ? cidx + 3'd1 : cidx;
        run_vec   = cidx_n[2] ? lfsr_vec(lfsr_a_n, lfsr_b_n) : corner_vec(cidx_n[1:0]);
        first_vec = corner_vec(2'd0);
    end
`else
    always_comb begin
        lfsr_a_n  = lfsr_step(lfsr_a);
        lfsr_b_n  = lfsr_step(lfsr_b);
        run_vec   = lfsr_vec(lfsr_a_n, lfsr_b_n);
        first_vec = lfsr_vec(SEED, SEED_B);
    end
`endif

    always_comb begin
        cnt_inc   = vec_count + 32'd1;
        last      = (cnt_inc == 32'(NUM_VECTORS));
        run_sum   = vec_sum(run_vec);
        first_sum = vec_sum(first_vec);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            lfsr_a    <= SEED;
            lfsr_b    <= SEED_B;
            vec_count <= '0;
`ifdef VECGEN_CORNER_EN
            cidx      <= '0;
`endif
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cin       <= 1'b0;
            a         <= '0;
            b         <= '0;
            exp_s     <= '0;
            exp_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        lfsr_a    <= SEED;
                        lfsr_b    <= SEED_B;
                        vec_count <= '0;
`ifdef VECGEN_CORNER_EN
                        cidx      <= '0;
`endif
                        vec_valid <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cin       <= first_vec.cin;
                        a         <= first_vec.a;
                        b         <= first_vec.b;
                        exp_s     <= first_sum[WIDTH-1:0];
                        exp_cout  <= first_sum[WIDTH];
                    end
                end
                RUN: begin
                    if (vec_ready) begin
                        vec_count <= cnt_inc;
                        lfsr_a    <= lfsr_a_n;
                        lfsr_b    <= lfsr_b_n;
`ifdef VECGEN_CORNER_EN
                        cidx      <= cidx_n;
`endif
                        if (last) begin
                            state     <= DONE;
                            vec_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cin       <= 1'b0;
                            a         <= '0;
                            b         <= '0;
                            exp_s     <= '0;
                            exp_cout  <= 1'b0;
                        end else begin
                            cin       <= run_vec.cin;
                            a         <= run_vec.a;
                            b         <= run_vec.b;
                            exp_s     <= run_sum[WIDTH-1:0];
                            exp_cout  <= run_sum[WIDTH];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
